seg_display_arbiter: RTL and testbench
======================================

# seg_display_arbiter

Shares the single seven-segment note display between two note sources: the live keyboard and the autoplay/playback engine. Each cycle it selects one owner and drives a registered `disp_music`/`disp_rot` pair into the segment scan driver. It applies four rules:
- keyboard priority;
- a minimum dwell time before the keyboard may preempt playback;
- an optional hold that keeps the last played key visible after release;
- blanking when idle.

## Interface
Parameters:
- `HOLD_CYC`, default 500: cycles (ms at 1 kHz) the last key note stays shown after release.
- `DWELL_CYC`, default 50: minimum cycles playback owns the display before the keyboard may preempt it.
- `CNT_W`, default 10: width of the hold and dwell counters. Must satisfy 2^CNT_W > max(HOLD_CYC, DWELL_CYC).

Ports:
- `clk_1khz` in 1: display-domain clock.
- `reset` in 1: asynchronous, active-high.
- `key_music` in 5: keyboard note code. Valid range is 1..21; 0 means no key.
- `key_rot` in 2: keyboard accidental (0 natural, 1 flat, 2 sharp).
- `play_en` in 1: playback engine active.
- `play_music` in 5: playback note code, valid range 1..21.
- `play_rot` in 2: playback accidental.
- `disp_music` out 5: note code to the display driver. 0 blanks the display.
- `disp_rot` out 2: accidental to the display driver.
- `owner` out 2: current owner. 00 none, 01 key, 10 play, 11 never driven.
- `switch_pulse` out 1: one-cycle strobe on every change of `owner`.

## Operation
- Request validity:
  - `key_valid` = `key_music` in 1..21.
  - `play_valid` = `play_en` and `play_music` in 1..21.
  - Codes 0 and 22..31 are treated as no request.
- States: IDLE, KEY, HOLD, PLAY.
- Outputs per state:
  - IDLE: owner=00, `disp_music`=0, `disp_rot`=0.
  - KEY: owner=01.
  - HOLD: owner=01.
  - PLAY: owner=10.
- Transitions, evaluated at each clock edge, first match wins:
  - IDLE: `key_valid` → KEY; `play_valid` → PLAY; otherwise stay.
  - KEY, while `key_valid`: stay. Register `key_music`/`key_rot` into `disp_*` every cycle.
  - KEY, on `!key_valid`: → HOLD. Load `hold_cnt` = HOLD_CYC−1. `disp_*` freezes at the last valid key note.
  - HOLD:
    - `key_valid` → KEY immediately; `hold_cnt` is discarded.
    - Else if `hold_cnt`==0: → PLAY if `play_valid`, else → IDLE.
    - Otherwise decrement `hold_cnt` and stay.
  - PLAY:
    - `key_valid` and `dwell_cnt`==DWELL_CYC−1 → KEY.
    - `key_valid` before the dwell expires: stay in PLAY. The preemption is deferred, not dropped.
    - `!play_valid` → KEY if `key_valid`, else IDLE. The dwell rule does not apply here.
    - Otherwise stay and track `play_music`/`play_rot`.
- `dwell_cnt`:
  - Cleared on every state-entry edge.
  - Increments on every subsequent edge, saturating at DWELL_CYC−1.
- `disp_*` is loaded on the same edge as a state change, using the new owner's source, or 0 when entering IDLE.
- Simultaneous key and play requests from IDLE resolve to KEY.
- Playback never preempts KEY or HOLD.
- Accidentals pass through unmodified; legality of a flat or sharp is the display driver's concern.

## Timing
- Reset value of every output: `disp_music`=0, `disp_rot`=0, `owner`=00, `switch_pulse`=0. State is IDLE and both counters are 0.
- Reset takes effect immediately at any point, including mid-HOLD or mid-PLAY.
- Latency:
  - 1 cycle from a source change to `disp_*`.
  - `owner` and `switch_pulse` update on the same edge as `disp_*`.
- HOLD lasts exactly HOLD_CYC cycles. Key release sampled at edge N leads to leaving HOLD at edge N+HOLD_CYC.
- Keyboard preemption of PLAY occurs no earlier than DWELL_CYC cycles after entering PLAY.
- `switch_pulse` is high for exactly one cycle after any edge on which `owner` changes. It stays low on KEY↔HOLD transitions, because `owner` remains 01.

## Configuration
- `SEG_ARB_HOLD_EN` defined: HOLD state and `hold_cnt` are present, as described above.
- `SEG_ARB_HOLD_EN` undefined:
  - HOLD and `hold_cnt` are removed and `HOLD_CYC` is ignored.
  - KEY on `!key_valid` goes directly to PLAY if `play_valid`, else to IDLE.

## Test plan
- Reset, then key 9/rot 2 for 3 cycles → `disp_music`=9, `disp_rot`=2, owner=01 one cycle after the key asserts; `switch_pulse` high once.
- Key 5 released with HOLD_CYC=4 (HOLD_EN) → `disp_music` stays 5 for 4 cycles, then drops to 0 with owner=00. With HOLD_EN undefined it drops to 0 the cycle after release.
- `play_en` with 12 and key 3 asserted on the same cycle from IDLE → owner=01, `disp_music`=3.
- PLAY of 15 with DWELL_CYC=8, key 2 asserted at PLAY cycle 2 → display holds 15 until cycle 8, then shows 2 with owner=01.
- `key_music`=22 or `play_music`=0 with `play_en`=1 → treated as no request; owner stays 00 and `disp_music`=0.
- `reset` pulsed mid-HOLD → all outputs 0 immediately; no stale note appears after reset drops.

Source files
------------

// File: rtl/seg_display_arbiter.sv
// Arbitrates the shared seven-segment note display between the live keyboard and the playback engine.
// Define SEG_ARB_HOLD_EN to keep the last key note visible for HOLD_CYC cycles after the key is released.
module seg_display_arbiter #(
    parameter int HOLD_CYC  = 500,
    parameter int DWELL_CYC = 50,
    parameter int CNT_W     = 10
) (
    input  logic       clk_1khz,
    input  logic       reset,
    input  logic [4:0] key_music,
    input  logic [1:0] key_rot,
    input  logic       play_en,
    input  logic [4:0] play_music,
    input  logic [1:0] play_rot,
    output logic [4:0] disp_music,
    output logic [1:0] disp_rot,
    output logic [1:0] owner,
    output logic       switch_pulse
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_KEY  = 2'd1,
        S_HOLD = 2'd2,
        S_PLAY = 2'd3
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_KEY  = 2'b01;
    localparam logic [1:0] OWN_PLAY = 2'b10;

    localparam int CNT_MAX = (HOLD_CYC > DWELL_CYC) ? HOLD_CYC : DWELL_CYC;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);

    // Counters saturate or load at these values, so they must fit in CNT_W bits.
    if (CNT_MAX >= (2 ** CNT_W)) begin : g_cnt_w_too_small
        $error("seg_display_arbiter: CNT_W too small for HOLD_CYC/DWELL_CYC");
    end

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] dwell_cnt;
    logic [4:0]       disp_music_next;
    logic [1:0]       disp_rot_next;
    logic             key_valid;
    logic             play_valid;

`ifdef SEG_ARB_HOLD_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    logic [CNT_W-1:0] hold_cnt;
`endif

    function automatic logic [1:0] owner_of(input state_t s);
        case (s)
            S_KEY, S_HOLD: owner_of = OWN_KEY;
            S_PLAY:        owner_of = OWN_PLAY;
            default:       owner_of = OWN_NONE;
        endcase
    endfunction

    // Codes 0 and 22..31 are not notes and count as "no request".
    assign key_valid  = (key_music >= 5'd1) && (key_music <= 5'd21);
    assign play_valid = play_en && (play_music >= 5'd1) && (play_music <= 5'd21);

    // State register: state, counters and the registered display pair.
    always_ff @(posedge clk_1khz or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            dwell_cnt    <= '0;
            disp_music   <= 5'd0;
            disp_rot     <= 2'd0;
            switch_pulse <= 1'b0;
        end else begin
            // NOTE: every register in this block uses <= so all of them sample the pre-edge values.
            state        <= state_next;
            disp_music   <= disp_music_next;
            disp_rot     <= disp_rot_next;
            switch_pulse <= (owner_of(state_next) != owner_of(state));
            if (state_next != state) begin
                dwell_cnt <= '0;
            end else if (dwell_cnt != DWELL_LAST) begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end
    end

`ifdef SEG_ARB_HOLD_EN
    always_ff @(posedge clk_1khz or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (state == S_KEY && state_next == S_HOLD) begin
            hold_cnt <= HOLD_LAST;
        end else if (state == S_HOLD && state_next == S_HOLD) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end
`endif

    // Next-state and next-display selection; first matching rule wins.
    always_comb begin
        // NOTE: defaults first so no path through the case can infer a latch.
        state_next      = state;
        disp_music_next = disp_music;
        disp_rot_next   = disp_rot;

        case (state)
            S_IDLE: begin
                if (key_valid) begin
                    state_next      = S_KEY;
                    disp_music_next = key_music;
                    disp_rot_next   = key_rot;
                end else if (play_valid) begin
                    state_next      = S_PLAY;
                    disp_music_next = play_music;
                    disp_rot_next   = play_rot;
                end else begin
                    disp_music_next = 5'd0;
                    disp_rot_next   = 2'd0;
                end
            end

            S_KEY: begin
                if (key_valid) begin
                    disp_music_next = key_music;
                    disp_rot_next   = key_rot;
                end else begin
`ifdef SEG_ARB_HOLD_EN
                    state_next = S_HOLD;
`else
                    if (play_valid) begin
                        state_next      = S_PLAY;
                        disp_music_next = play_music;
                        disp_rot_next   = play_rot;
                    end else begin
                        state_next      = S_IDLE;
                        disp_music_next = 5'd0;
                        disp_rot_next   = 2'd0;
                    end
`endif
                end
            end

`ifdef SEG_ARB_HOLD_EN
            S_HOLD: begin
                if (key_valid) begin
                    state_next      = S_KEY;
                    disp_music_next = key_music;
                    disp_rot_next   = key_rot;
                end else if (hold_cnt == '0) begin
                    if (play_valid) begin
                        state_next      = S_PLAY;
                        disp_music_next = play_music;
                        disp_rot_next   = play_rot;
                    end else begin
                        state_next      = S_IDLE;
                        disp_music_next = 5'd0;
                        disp_rot_next   = 2'd0;
                    end
                end
            end
`endif

            S_PLAY: begin
                if (key_valid && dwell_cnt == DWELL_LAST) begin
                    state_next      = S_KEY;
                    disp_music_next = key_music;
                    disp_rot_next   = key_rot;
                end else if (!play_valid) begin
                    // Playback dropped out: the keyboard takes over without waiting for dwell.
                    if (key_valid) begin
                        state_next      = S_KEY;
                        disp_music_next = key_music;
                        disp_rot_next   = key_rot;
                    end else begin
                        state_next      = S_IDLE;
                        disp_music_next = 5'd0;
                        disp_rot_next   = 2'd0;
                    end
                end else begin
                    disp_music_next = play_music;
                    disp_rot_next   = play_rot;
                end
            end

            default: begin
                state_next      = S_IDLE;
                disp_music_next = 5'd0;
                disp_rot_next   = 2'd0;
            end
        endcase
    end

    // Output decode: owner follows the registered state directly.
    always_comb begin
        owner = owner_of(state);
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter: directed steps push expected outputs, a monitor pops and compares.
// Expectations follow whichever build of SEG_ARB_HOLD_EN is compiled.
module tb_seg_display_arbiter;

    localparam int HOLD_CYC  = 4;
    localparam int DWELL_CYC = 8;
    localparam int CNT_W     = 4;
`ifdef SEG_ARB_HOLD_EN
    localparam int HOLD_STEPS = HOLD_CYC;
`else
    localparam int HOLD_STEPS = 0;
`endif

    logic       clk_1khz = 1'b0;
    logic       reset;
    logic [4:0] key_music;
    logic [1:0] key_rot;
    logic       play_en;
    logic [4:0] play_music;
    logic [1:0] play_rot;
    logic [4:0] disp_music;
    logic [1:0] disp_rot;
    logic [1:0] owner;
    logic       switch_pulse;

    typedef struct {
        logic [4:0] m;
        logic [1:0] r;
        logic [1:0] o;
        logic       p;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   step_no = 0;

    seg_display_arbiter #(
        .HOLD_CYC (HOLD_CYC),
        .DWELL_CYC(DWELL_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_1khz    (clk_1khz),
        .reset       (reset),
        .key_music   (key_music),
        .key_rot     (key_rot),
        .play_en     (play_en),
        .play_music  (play_music),
        .play_rot    (play_rot),
        .disp_music  (disp_music),
        .disp_rot    (disp_rot),
        .owner       (owner),
        .switch_pulse(switch_pulse)
    );

    always #5 clk_1khz = ~clk_1khz;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Drive one cycle of inputs (called just after a negedge) and queue the outputs expected after the next posedge.
    task automatic step(input logic [4:0] km, input logic [1:0] kr, input logic pe,
                        input logic [4:0] pm, input logic [1:0] pr,
                        input logic [4:0] em, input logic [1:0] er,
                        input logic [1:0] eo, input logic ep);
        exp_t e;
        key_music  = km;
        key_rot    = kr;
        play_en    = pe;
        play_music = pm;
        play_rot   = pr;
        e.m  = em;
        e.r  = er;
        e.o  = eo;
        e.p  = ep;
        e.id = step_no;
        exp_q.push_back(e);
        step_no++;
        @(negedge clk_1khz);
    endtask

    // Key released while the play inputs are held; the held note lingers only in the HOLD build.
    task automatic release_key(input logic [4:0] hm, input logic [1:0] hr, input logic pe,
                               input logic [4:0] pm, input logic [1:0] pr,
                               input logic [4:0] am, input logic [1:0] ar, input logic [1:0] ao);
        for (int i = 0; i < HOLD_STEPS; i++) step(5'd0, 2'd0, pe, pm, pr, hm, hr, 2'b01, 1'b0);
        step(5'd0, 2'd0, pe, pm, pr, am, ar, ao, 1'b1);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk_1khz);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("step%0d disp_music", e.id), disp_music, e.m);
                check($sformatf("step%0d disp_rot", e.id), disp_rot, e.r);
                check($sformatf("step%0d owner", e.id), owner, e.o);
                check($sformatf("step%0d switch_pulse", e.id), switch_pulse, e.p);
            end
        end
    end

    initial begin
        int waited;
        reset      = 1'b1;
        key_music  = 5'd0;
        key_rot    = 2'd0;
        play_en    = 1'b0;
        play_music = 5'd0;
        play_rot   = 2'd0;
        @(negedge clk_1khz);

        // Reset state.
        step(5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00, 1'b0);
        step(5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00, 1'b0);
        reset = 1'b0;

        // Key 9/sharp for three cycles, change to key 5/flat, then release.
        step(5'd9, 2'd2, 1'b0, 5'd0, 2'd0, 5'd9, 2'd2, 2'b01, 1'b1);
        step(5'd9, 2'd2, 1'b0, 5'd0, 2'd0, 5'd9, 2'd2, 2'b01, 1'b0);
        step(5'd9, 2'd2, 1'b0, 5'd0, 2'd0, 5'd9, 2'd2, 2'b01, 1'b0);
        step(5'd5, 2'd1, 1'b0, 5'd0, 2'd0, 5'd5, 2'd1, 2'b01, 1'b0);
        release_key(5'd5, 2'd1, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00);
        step(5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00, 1'b0);

        // Re-press during HOLD, then release into waiting playback, then playback stops.
        step(5'd7, 2'd0, 1'b0, 5'd0, 2'd0, 5'd7, 2'd0, 2'b01, 1'b1);
`ifdef SEG_ARB_HOLD_EN
        step(5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 5'd7, 2'd0, 2'b01, 1'b0);
        step(5'd4, 2'd1, 1'b0, 5'd0, 2'd0, 5'd4, 2'd1, 2'b01, 1'b0);
`else
        step(5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00, 1'b1);
        step(5'd4, 2'd1, 1'b0, 5'd0, 2'd0, 5'd4, 2'd1, 2'b01, 1'b1);
`endif
        release_key(5'd4, 2'd1, 1'b1, 5'd12, 2'd2, 5'd12, 2'd2, 2'b10);
        step(5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00, 1'b1);

        // Simultaneous key and play from IDLE: keyboard wins.
        step(5'd3, 2'd0, 1'b1, 5'd12, 2'd1, 5'd3, 2'd0, 2'b01, 1'b1);
        release_key(5'd3, 2'd0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00);

        // Dwell: play 15, key 2 arrives at PLAY cycle 2, preempts at cycle 8.
        step(5'd0, 2'd0, 1'b1, 5'd15, 2'd0, 5'd15, 2'd0, 2'b10, 1'b1);
        step(5'd0, 2'd0, 1'b1, 5'd17, 2'd1, 5'd17, 2'd1, 2'b10, 1'b0);
        for (int i = 0; i < 6; i++) step(5'd2, 2'd2, 1'b1, 5'd15, 2'd0, 5'd15, 2'd0, 2'b10, 1'b0);
        step(5'd2, 2'd2, 1'b1, 5'd15, 2'd0, 5'd2, 2'd2, 2'b01, 1'b1);
        release_key(5'd2, 2'd2, 1'b1, 5'd15, 2'd0, 5'd15, 2'd0, 2'b10);

        // Playback stops while a key is down: keyboard takes over without dwell.
        step(5'd6, 2'd0, 1'b0, 5'd15, 2'd0, 5'd6, 2'd0, 2'b01, 1'b1);
        release_key(5'd6, 2'd0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00);

        // Out-of-range codes are no request.
        step(5'd22, 2'd1, 1'b1, 5'd0, 2'd2, 5'd0, 2'd0, 2'b00, 1'b0);
        step(5'd31, 2'd0, 1'b0, 5'd5, 2'd0, 5'd0, 2'd0, 2'b00, 1'b0);
        step(5'd0, 2'd0, 1'b1, 5'd22, 2'd0, 5'd0, 2'd0, 2'b00, 1'b0);

        // Reset pulsed mid-HOLD clears outputs immediately and leaves no stale note.
        step(5'd11, 2'd1, 1'b0, 5'd0, 2'd0, 5'd11, 2'd1, 2'b01, 1'b1);
`ifdef SEG_ARB_HOLD_EN
        step(5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 5'd11, 2'd1, 2'b01, 1'b0);
`else
        step(5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00, 1'b1);
`endif
        reset = 1'b1;
        #1;
        check("async_rst disp_music", disp_music, 0);
        check("async_rst disp_rot", disp_rot, 0);
        check("async_rst owner", owner, 0);
        check("async_rst switch_pulse", switch_pulse, 0);
        step(5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step(5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00, 1'b0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk_1khz);
            waited++;
        end
        check("scoreboard drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
